// File: rtl/kvadd2_multi_counter.sv
// Multi-channel up/down counter with variable step, registered zero/max flags and overflow/underflow pulses.
// Wraps by default; define KVADD2_MULTI_COUNTER_SAT_EN to saturate instead.
module kvadd2_multi_counter #(
  parameter int                 C_CHANNELS   = 2,
  parameter int                 C_WIDTH      = 8,
  parameter int                 C_STEP_WIDTH = 4,
  parameter logic [C_WIDTH-1:0] C_INIT       = {C_WIDTH{1'b0}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clken,
  input  logic [C_CHANNELS-1:0]              load,
  input  logic [C_CHANNELS*C_WIDTH-1:0]      load_value,
  input  logic [C_CHANNELS-1:0]              incr,
  input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] incr_step,
  input  logic [C_CHANNELS-1:0]              decr,
  input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] decr_step,
  output logic [C_CHANNELS*C_WIDTH-1:0]      count,
  output logic [C_CHANNELS-1:0]              is_zero,
  output logic [C_CHANNELS-1:0]              is_max,
  output logic [C_CHANNELS-1:0]              overflow,
  output logic [C_CHANNELS-1:0]              underflow
);

  localparam int W  = C_WIDTH;
  localparam int SW = C_STEP_WIDTH;

  function automatic logic f_is_zero(input logic [W-1:0] v);
    return (v == {W{1'b0}});
  endfunction

  function automatic logic f_is_max(input logic [W-1:0] v);
    return (v == {W{1'b1}});
  endfunction

  for (genvar g = 0; g < C_CHANNELS; g++) begin : g_ch
    logic [W-1:0]        r_count     = C_INIT;
    logic                r_is_zero   = f_is_zero(C_INIT);
    logic                r_is_max    = f_is_max(C_INIT);
    logic                r_overflow  = 1'b0;
    logic                r_underflow = 1'b0;
    logic [SW-1:0]       w_a;
    logic [SW-1:0]       w_b;
    logic signed [W+1:0] w_sum;
    logic [W-1:0]        w_next;
    logic                w_ovf;
    logic                w_unf;

    // The W+2 bit signed sum holds every reachable result: bit W+1 marks a negative sum, bit W a carry past the top.
    always_comb begin
      w_a    = incr[g] ? incr_step[g*SW +: SW] : {SW{1'b0}};
      w_b    = decr[g] ? decr_step[g*SW +: SW] : {SW{1'b0}};
      w_sum  = $signed({2'b00, r_count})
             + $signed({{(W+2-SW){1'b0}}, w_a})
             - $signed({{(W+2-SW){1'b0}}, w_b});
      w_ovf  = 1'b0;
      w_unf  = 1'b0;
      w_next = w_sum[W-1:0];
      if (w_sum[W+1]) begin
        w_unf = 1'b1;
`ifdef KVADD2_MULTI_COUNTER_SAT_EN
        w_next = {W{1'b0}};
`endif
      end else if (w_sum[W]) begin
        w_ovf = 1'b1;
`ifdef KVADD2_MULTI_COUNTER_SAT_EN
        w_next = {W{1'b1}};
`endif
      end else begin
        w_next = w_sum[W-1:0];
      end
    end

    // Channel state: reset, then enable, then load, then step update; flags follow the value being written.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_count     <= C_INIT;
        r_is_zero   <= f_is_zero(C_INIT);
        r_is_max    <= f_is_max(C_INIT);
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else if (!clken) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else if (load[g]) begin
        r_count     <= load_value[g*W +: W];
        r_is_zero   <= f_is_zero(load_value[g*W +: W]);
        r_is_max    <= f_is_max(load_value[g*W +: W]);
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        r_count     <= w_next;
        r_is_zero   <= f_is_zero(w_next);
        r_is_max    <= f_is_max(w_next);
        r_overflow  <= w_ovf;
        r_underflow <= w_unf;
      end
    end

    assign count[g*W +: W] = r_count;
    assign is_zero[g]      = r_is_zero;
    assign is_max[g]       = r_is_max;
    assign overflow[g]     = r_overflow;
    assign underflow[g]    = r_underflow;
  end

endmodule

// File: tb/tb_kvadd2_multi_counter.sv
// Directed scoreboard bench for kvadd2_multi_counter (two channels, 8-bit, 4-bit steps).
module tb_kvadd2_multi_counter;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam logic [W-1:0] INIT = 8'h05;

  typedef struct packed {
    logic [N*W-1:0] cnt;
    logic [N-1:0]   z;
    logic [N-1:0]   m;
    logic [N-1:0]   o;
    logic [N-1:0]   u;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst, clken;
  logic [N-1:0]    load, incr, decr;
  logic [N*W-1:0]  load_value;
  logic [N*SW-1:0] incr_step, decr_step;
  logic [N*W-1:0]  count, count0;
  logic [N-1:0]    is_zero, is_max, overflow, underflow;
  logic [N-1:0]    is_zero0, is_max0, overflow0, underflow0;

  exp_t q_exp[$];
  int   m_cnt[N];
  int   n_pass = 0;
  int   n_total = 0;

  kvadd2_multi_counter #(.C_CHANNELS(N), .C_WIDTH(W), .C_STEP_WIDTH(SW), .C_INIT(INIT)) dut (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .load_value(load_value),
    .incr(incr), .incr_step(incr_step), .decr(decr), .decr_step(decr_step),
    .count(count), .is_zero(is_zero), .is_max(is_max),
    .overflow(overflow), .underflow(underflow));

  kvadd2_multi_counter #(.C_CHANNELS(N), .C_WIDTH(W), .C_STEP_WIDTH(SW), .C_INIT(8'h00)) dut0 (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .load_value(load_value),
    .incr(incr), .incr_step(incr_step), .decr(decr), .decr_step(decr_step),
    .count(count0), .is_zero(is_zero0), .is_max(is_max0),
    .overflow(overflow0), .underflow(underflow0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic cyc(input logic r, input logic ce, input logic [N-1:0] ld,
                     input logic [7:0] lv0, input logic [7:0] lv1,
                     input logic [N-1:0] inc, input logic [3:0] is0, input logic [3:0] is1,
                     input logic [N-1:0] dec, input logic [3:0] ds0, input logic [3:0] ds1,
                     input string tag);
    exp_t e;
    int   s, a, b;
    logic [7:0] lv [N];
    logic [3:0] ist [N];
    logic [3:0] dst [N];
    lv[0] = lv0; lv[1] = lv1; ist[0] = is0; ist[1] = is1; dst[0] = ds0; dst[1] = ds1;
    rst = r; clken = ce; load = ld; incr = inc; decr = dec;
    load_value = {lv1, lv0}; incr_step = {is1, is0}; decr_step = {ds1, ds0};
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (r) m_cnt[i] = int'(INIT);
      else if (!ce) m_cnt[i] = m_cnt[i];
      else if (ld[i]) m_cnt[i] = int'(lv[i]);
      else begin
        a = inc[i] ? int'(ist[i]) : 0;
        b = dec[i] ? int'(dst[i]) : 0;
        s = m_cnt[i] + a - b;
        if (s > 255) begin
          e.o[i] = 1'b1;
`ifdef KVADD2_MULTI_COUNTER_SAT_EN
          m_cnt[i] = 255;
`else
          m_cnt[i] = s - 256;
`endif
        end else if (s < 0) begin
          e.u[i] = 1'b1;
`ifdef KVADD2_MULTI_COUNTER_SAT_EN
          m_cnt[i] = 0;
`else
          m_cnt[i] = s + 256;
`endif
        end else m_cnt[i] = s;
      end
      e.cnt[i*W +: W] = m_cnt[i][7:0];
      e.z[i] = (m_cnt[i] == 0);
      e.m[i] = (m_cnt[i] == 255);
    end
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = q_exp.pop_front();
      chk({tag, " count"}, 32'(count), 32'(e.cnt));
      chk({tag, " is_zero"}, 32'(is_zero), 32'(e.z));
      chk({tag, " is_max"}, 32'(is_max), 32'(e.m));
      chk({tag, " overflow"}, 32'(overflow), 32'(e.o));
      chk({tag, " underflow"}, 32'(underflow), 32'(e.u));
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rst = 1'b0; clken = 1'b0; load = '0; incr = '0; decr = '0;
    load_value = '0; incr_step = '0; decr_step = '0;

    cyc(1'b1, 1'b1, 2'b00, 8'd0, 8'd0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, "reset1");
    cyc(1'b1, 1'b1, 2'b00, 8'd0, 8'd0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, "reset2");
    chk("init0 count", 32'(count0), 32'd0);
    chk("init0 is_zero", 32'(is_zero0), 32'd3);
    chk("init0 is_max", 32'(is_max0), 32'd0);
    chk("init0 pulses", 32'({overflow0, underflow0}), 32'd0);

    cyc(1'b0, 1'b1, 2'b11, 8'd10, 8'd20, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, "load10_20");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 8'd0, 2'b11, 4'd3, 4'd4, 2'b11, 4'd7, 4'd4, "net_delta");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 8'd0, 2'b01, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, "zero_step");

    cyc(1'b0, 1'b1, 2'b11, 8'd254, 8'd2, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, "load254_2");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 8'd0, 2'b01, 4'd5, 4'd0, 2'b10, 4'd0, 4'd4, "ovf_unf");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 8'd0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, "pulse_clear");
    cyc(1'b0, 1'b1, 2'b11, 8'd254, 8'd0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, "load254_0");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 8'd0, 2'b11, 4'd1, 4'd0, 2'b10, 4'd0, 4'd1, "to_max_unf1");
    cyc(1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 2'b11, 4'd9, 4'd9, 2'b00, 4'd0, 4'd0, "clken0_clear");

    cyc(1'b0, 1'b1, 2'b11, 8'd0, 8'd255, 2'b11, 4'd5, 4'd5, 2'b00, 4'd0, 4'd0, "load_prio");
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 2'b11, 4'd15, 4'd15, 2'b00, 4'd0, 4'd0, "hold");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 8'd0, 2'b11, 4'd15, 4'd15, 2'b00, 4'd0, 4'd0, "resume");

    cyc(1'b0, 1'b1, 2'b11, 8'd254, 8'd254, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, "load254_254");
    cyc(1'b1, 1'b1, 2'b11, 8'd7, 8'd7, 2'b11, 4'd5, 4'd5, 2'b00, 4'd0, 4'd0, "rst_mid");
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 8'd0, 2'b11, 4'd2, 4'd15, 2'b01, 4'd8, 4'd0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kvadd2_multi_counter.md
# kvadd2_multi_counter

Multi-channel parametrised up/down counter: the next-generation general-purpose counter for kvadd2 control logic (AXI burst/transaction tracking, outstanding-request credits, beat counting). Provides `C_CHANNELS` independent counters with variable step, simultaneous increment/decrement, and registered zero/max flags. Also provides registered overflow/underflow pulses. Overflow handling is wrap-around by default and saturating when compiled with the configuration macro.

## Interface

Parameters:
- `C_CHANNELS`, 2, number of independent counter channels (≥1).
- `C_WIDTH`, 8, counter width per channel (≥2).
- `C_STEP_WIDTH`, 4, width of the step inputs (1 ≤ `C_STEP_WIDTH` ≤ `C_WIDTH`).
- `C_INIT`, all zeros, reset/initial value of every channel, `C_WIDTH` bits.

Ports (channel `i` occupies bits `[i*W +: W]` of each flattened bus):
- `clk`  in  1  clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clken`  in  1  global clock enable, shared by all channels.
- `load`  in  `C_CHANNELS`  per-channel load strobe.
- `load_value`  in  `C_CHANNELS*C_WIDTH`  per-channel load value.
- `incr`  in  `C_CHANNELS`  per-channel increment strobe.
- `incr_step`  in  `C_CHANNELS*C_STEP_WIDTH`  per-channel increment amount (unsigned).
- `decr`  in  `C_CHANNELS`  per-channel decrement strobe.
- `decr_step`  in  `C_CHANNELS*C_STEP_WIDTH`  per-channel decrement amount (unsigned).
- `count`  out  `C_CHANNELS*C_WIDTH`  registered counter values.
- `is_zero`  out  `C_CHANNELS`  registered; high when the channel's `count` is 0.
- `is_max`  out  `C_CHANNELS`  registered; high when the channel's `count` is all ones.
- `overflow`  out  `C_CHANNELS`  one-cycle pulse: the last update exceeded `2^C_WIDTH-1`.
- `underflow`  out  `C_CHANNELS`  one-cycle pulse: the last update went below 0.

## Operation

- Channels are fully independent; only `clk`, `rst` and `clken` are shared.
- Per-channel priority: `rst` > `clken`=0 > `load` > step update.
- `rst`=1:
  - `count` = `C_INIT`.
  - `is_zero` = (`C_INIT`==0).
  - `is_max` = (`C_INIT`==all ones).
  - `overflow` = `underflow` = 0.
- `clken`=0: `count`, `is_zero` and `is_max` hold; `overflow` and `underflow` clear to 0.
- `load`=1: `count` ← `load_value`. Flags are recomputed from `load_value`. `incr`/`decr` are ignored. No overflow or underflow pulse.
- Step update:
  - Effective increment `a = incr ? incr_step : 0`; effective decrement `b = decr ? decr_step : 0`, both zero-extended.
  - `sum = count + a - b`, evaluated in `C_WIDTH+2`-bit signed arithmetic.
  - `sum > 2^C_WIDTH-1` → overflow.
  - `sum < 0` → underflow.
  - Otherwise `count` ← `sum`.
  - Simultaneous `incr` and `decr` apply the net delta. Equal steps leave `count` unchanged with no pulse.
  - A step of 0 is legal and acts as a no-op.
- On overflow/underflow, the corresponding pulse is 1 for exactly one cycle. The new `count` depends on configuration (see below).
- `is_zero` and `is_max` always describe the registered `count`. They are computed from the next-state value, so they change in the same cycle as `count`, never one cycle later.

## Timing

- Latency: 1 cycle from an input sampled with `clken`=1 to updated `count`, flags and pulses.
- All outputs are driven directly from registers; there are no combinational input→output paths.
- Back-to-back updates are accepted every cycle.
- Reset mid-operation: takes effect on the next edge regardless of `load`/`incr`/`decr`. A pulse in flight is cleared.
- Registers also carry the reset values as power-up initial values (FPGA), so outputs are defined before the first reset.

## Configuration

- `KVADD2_MULTI_COUNTER_SAT_EN` not defined (default): wrap-around.
  - `count` ← `sum` mod `2^C_WIDTH`.
  - `is_zero`/`is_max` reflect the wrapped value.
- `KVADD2_MULTI_COUNTER_SAT_EN` defined: saturating.
  - On overflow `count` ← all ones.
  - On underflow `count` ← 0.
  - `overflow`/`underflow` pulses are still generated and mean "clipped".
- The macro affects every channel identically; the interface is unchanged.

## Test plan

- Reset/init: `C_INIT`=8'h05, assert `rst` 2 cycles → all `count`=5, `is_zero`=0, `is_max`=0, pulses 0. Repeat with `C_INIT`=0 → `is_zero`=1.
- Step arithmetic: ch0 `count`=10, `incr`=1 `incr_step`=3 with `decr`=1 `decr_step`=7 → `count`=6 next cycle. Same cycle ch1 `incr_step`=`decr_step`=4 → ch1 unchanged, no pulse.
- Wrap (macro off): `C_WIDTH`=8, `count`=254, `incr_step`=5 → `count`=3, `overflow`=1 one cycle, `is_max`=0. Then `count`=2, `decr_step`=4 → `count`=254, `underflow`=1.
- Saturate (macro on): same stimulus → `count`=255 with `is_max`=1 and `overflow`=1; then from 2, `decr_step`=4 → `count`=0 with `is_zero`=1 and `underflow`=1.
- Priority/enable: `load`=1 `load_value`=0 with `incr`=1 → `count`=0, `is_zero`=1, no pulse. With `clken`=0 and `incr` active for 3 cycles → `count` holds and pulses stay 0.
- Reset mid-operation: `rst` in the same cycle as `load` and an overflowing `incr` → `count`=`C_INIT` and `overflow`=0 on the next cycle, for all channels.
